king_move_exec: RTL and testbench



---
 rtl/king_move_exec.sv | 172 +++++++++++++++++
 tb/tb_king_move_exec.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/king_move_exec.sv
// King move executor: validates a latched direction request against turn, mask,
// board edges and king capture, then owns the 8x8 board with a two-step write.
module king_move_exec (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_color,
  input  logic [2:0]            req_dir,
  input  logic [7:0]            king_allow,
  output logic                  done,
  output logic [1:0]            err,
  output logic                  capture,
  output logic [4:0]            captured_piece,
  output logic                  turn,
  output logic [2:0]            wk_row,
  output logic [2:0]            wk_col,
  output logic [2:0]            bk_row,
  output logic [2:0]            bk_col,
  output logic [7:0][7:0][4:0]  board,
  output logic [2:0]            state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_valid while req_ready is low is dropped.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WRITE_DST = 3'd2,
    CLEAR_SRC = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t state;

  logic              lat_color;
  logic [2:0]        lat_dir;
  logic [7:0]        lat_allow;
  logic [2:0]        dst_row, dst_col;
  logic [2:0]        src_row, src_col;
  logic signed [3:0] d_row, d_col;
  logic signed [3:0] n_row, n_col;
  logic              off_board;
  logic [4:0]        tgt_cell;
  logic [4:0]        dst_old;

  function automatic logic [4:0] start_cell(input logic [2:0] r, input logic [2:0] c);
    logic [2:0] back_type;
    case (c)
      3'd0, 3'd7: back_type = 3'b100;
      3'd1, 3'd6: back_type = 3'b010;
      3'd2, 3'd5: back_type = 3'b011;
      3'd3:       back_type = 3'b101;
      default:    back_type = 3'b110;
    endcase
    if (r == 3'd0 || r == 3'd7)      start_cell = {back_type, (r == 3'd0), 1'b1};
    else if (r == 3'd1 || r == 3'd6) start_cell = {3'b001, (r == 3'd1), 1'b1};
    else                             start_cell = 5'h00;
  endfunction

  assign state_dbg = state;
  assign src_row   = lat_color ? bk_row : wk_row;
  assign src_col   = lat_color ? bk_col : wk_col;

  always_comb begin
    d_row = 4'sd0;
    d_col = 4'sd0;
    case (lat_dir)
      3'd7: d_row = -4'sd1;
      3'd6: begin d_row = -4'sd1; d_col =  4'sd1; end
      3'd5: d_col =  4'sd1;
      3'd4: begin d_row =  4'sd1; d_col =  4'sd1; end
      3'd3: d_row =  4'sd1;
      3'd2: begin d_row =  4'sd1; d_col = -4'sd1; end
      3'd1: d_col = -4'sd1;
      default: begin d_row = -4'sd1; d_col = -4'sd1; end
    endcase
  end

  assign n_row = $signed({1'b0, src_row}) + d_row;
  assign n_col = $signed({1'b0, src_col}) + d_col;
  // Results span -1..8; both out-of-range values (4'b1111, 4'b1000) have bit 3 set.
  assign off_board = n_row[3] | n_col[3];
  assign tgt_cell  = board[n_row[2:0]][n_col[2:0]];
  assign dst_old   = board[dst_row][dst_col];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      done           <= 1'b0;
      err            <= 2'b00;
      capture        <= 1'b0;
      captured_piece <= 5'h00;
      turn           <= 1'b0;
      wk_row         <= 3'd7;
      wk_col         <= 3'd4;
      bk_row         <= 3'd0;
      bk_col         <= 3'd4;
      lat_color      <= 1'b0;
      lat_dir        <= 3'd0;
      lat_allow      <= 8'h00;
      dst_row        <= 3'd0;
      dst_col        <= 3'd0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r][c] <= start_cell(3'(r), 3'(c));
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_color      <= req_color;
            lat_dir        <= req_dir;
            lat_allow      <= king_allow;
            req_ready      <= 1'b0;
            err            <= 2'b00;
            capture        <= 1'b0;
            captured_piece <= 5'h00;
            state          <= CHECK;
          end
        end
        CHECK: begin
          if (lat_color != turn) begin
            err   <= 2'b01;
            done  <= 1'b1;
            state <= RESP;
          end else if (!lat_allow[lat_dir] || off_board) begin
            err   <= 2'b10;
            done  <= 1'b1;
            state <= RESP;
          end else if (tgt_cell[4:2] == 3'b110) begin
            err   <= 2'b11;
            done  <= 1'b1;
            state <= RESP;
          end else begin
            dst_row <= n_row[2:0];
            dst_col <= n_col[2:0];
            state   <= WRITE_DST;
          end
        end
        WRITE_DST: begin
          board[dst_row][dst_col] <= {3'b110, lat_color, 1'b1};
          if (dst_old[0] && (dst_old[1] != lat_color)) begin
            capture        <= 1'b1;
            captured_piece <= dst_old;
          end
          state <= CLEAR_SRC;
        end
        CLEAR_SRC: begin
          board[src_row][src_col] <= 5'h00;
          if (lat_color) begin
            bk_row <= dst_row;
            bk_col <= dst_col;
          end else begin
            wk_row <= dst_row;
            wk_col <= dst_col;
          end
          turn  <= ~turn;
          done  <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_king_move_exec.sv
// Bench for king_move_exec: directed game sequence plus random requests,
// compared against a chess-rule board model kept in the bench.
module tb_king_move_exec;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_color;
  logic [2:0]           req_dir;
  logic [7:0]           king_allow;
  logic                 done;
  logic [1:0]           err;
  logic                 capture;
  logic [4:0]           captured_piece;
  logic                 turn;
  logic [2:0]           wk_row, wk_col, bk_row, bk_col;
  logic [7:0][7:0][4:0] board;
  logic [2:0]           state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [4:0] mb [8][8];
  logic       m_turn;
  int         m_wr, m_wc, m_br, m_bc;

  king_move_exec dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_color(req_color), .req_dir(req_dir), .king_allow(king_allow),
    .done(done), .err(err), .capture(capture), .captured_piece(captured_piece),
    .turn(turn), .wk_row(wk_row), .wk_col(wk_col), .bk_row(bk_row), .bk_col(bk_col),
    .board(board), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[r][c] = 5'h00;
    for (int c = 0; c < 8; c++) begin
      mb[0][c] = 5'((back[c] << 2) | 3);
      mb[1][c] = 5'((1 << 2) | 3);
      mb[6][c] = 5'((1 << 2) | 1);
      mb[7][c] = 5'((back[c] << 2) | 1);
    end
    m_turn = 1'b0;
    m_wr = 7; m_wc = 4; m_br = 0; m_bc = 4;
  endtask

  task automatic model_step(input logic c, input logic [2:0] d, input logic [7:0] m,
                            output int e, output logic cap, output logic [4:0] cp,
                            output int nr, output int nc);
    int drow [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dcol [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    int sr, sc;
    logic off;
    logic [4:0] old;
    sr = c ? m_br : m_wr;
    sc = c ? m_bc : m_wc;
    nr = sr + drow[d];
    nc = sc + dcol[d];
    off = (nr < 0) || (nr > 7) || (nc < 0) || (nc > 7);
    cap = 1'b0;
    cp  = 5'h00;
    if (c != m_turn)                  e = 1;
    else if (!m[d] || off)            e = 2;
    else if (mb[nr][nc] >= 5'h18 && mb[nr][nc] <= 5'h1B) e = 3;
    else begin
      e = 0;
      old = mb[nr][nc];
      if (old[0] && old[1] != c) begin
        cap = 1'b1;
        cp  = old;
      end
      mb[nr][nc] = c ? 5'h1B : 5'h19;
      mb[sr][sc] = 5'h00;
      if (c) begin m_br = nr; m_bc = nc; end
      else   begin m_wr = nr; m_wc = nc; end
      m_turn = ~m_turn;
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0][7:0][4:0] exp_b;
    int bad_r, bad_c;
    bad_r = -1; bad_c = -1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        exp_b[r][c] = mb[r][c];
        if (board[r][c] !== mb[r][c] && bad_r < 0) begin bad_r = r; bad_c = c; end
      end
    checks++;
    assert (board === exp_b) else begin
      errors++;
      $error("FAIL %s_board: cell (%0d,%0d) observed %0h expected %0h", tag, bad_r, bad_c,
             board[bad_r[2:0]][bad_c[2:0]], mb[bad_r[2:0]][bad_c[2:0]]);
    end
    check({tag, "_turn"}, 32'(turn), 32'(m_turn));
    check({tag, "_wk"}, {26'd0, wk_row, wk_col}, 32'((m_wr << 3) | m_wc));
    check({tag, "_bk"}, {26'd0, bk_row, bk_col}, 32'((m_br << 3) | m_bc));
  endtask

  task automatic do_req(input logic c, input logic [2:0] d, input logic [7:0] m,
                        output logic [1:0] o_err, output logic [4:0] o_cp);
    int e, nr, nc, lat;
    logic cap;
    logic [4:0] cp;
    bit seen;
    model_step(c, d, m, e, cap, cp, nr, nc);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_color = c; req_dir = d; king_allow = m;
    @(posedge clk);
    #1;
    // Keep valid asserted with scrambled inputs: these must be ignored while busy.
    req_color = 1'($urandom); req_dir = 3'($urandom); king_allow = 8'($urandom);
    check("ready_busy", 32'(req_ready), 32'd0);
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (e == 0 && lat == 2)
        check("mid_dst", 32'(board[nr[2:0]][nc[2:0]]), c ? 32'h1B : 32'h19);
      if (done) seen = 1;
    end
    req_valid = 1'b0;
    check("done_latency", 32'(lat), (e == 0) ? 32'd3 : 32'd1);
    check("err", 32'(err), 32'(e));
    check("capture", 32'(capture), 32'(cap));
    check("captured_piece", 32'(captured_piece), 32'(cp));
    check("ready_resp", 32'(req_ready), 32'd0);
    o_err = err;
    o_cp  = captured_piece;
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    check_state("post");
  endtask

  // Directed game: walks both kings to exercise reject codes and captures.
  int         t_c  [23] = '{0,1,0,1,0,1,0,1,0,1,0,1,0,1,1,0,1,0,1,0,1,0,1};
  int         t_d  [23] = '{7,7,7,3,1,3,5,3,1,3,5,3,1,2,4,5,3,1,6,5,5,1,5};
  logic [7:0] t_m  [23] = '{8'h00,8'h80,8'h80,8'h08,8'h02,8'h08,8'h20,8'h08,8'h02,8'h08,8'h20,8'h08,
                            8'h02,8'h04,8'h10,8'h20,8'h08,8'h02,8'h40,8'h20,8'h20,8'h02,8'h20};
  int         t_e  [23] = '{2,1,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0,0,0,0,0,2};
  logic [4:0] t_cp [23] = '{5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,
                            5'h00,5'h00,5'h05,5'h00,5'h0D,5'h00,5'h05,5'h00,5'h05,5'h00,5'h00};

  initial begin
    logic [1:0] got_err;
    logic [4:0] got_cp;
    logic       rc;
    reset = 1'b1; req_valid = 1'b0; req_color = 1'b0; req_dir = 3'd0; king_allow = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_capture", 32'(capture), 32'd0);
    check("rst_cp", 32'(captured_piece), 32'd0);
    check("rst_bk_cell", 32'(board[0][4]), 32'h1B);
    check("rst_wk_cell", 32'(board[7][4]), 32'h19);
    check_state("rst");

    for (int i = 0; i < 23; i++) begin
      do_req(t_c[i][0], 3'(t_d[i]), t_m[i], got_err, got_cp);
      check($sformatf("dir_err_%0d", i), 32'(got_err), 32'(t_e[i]));
      check($sformatf("dir_cp_%0d", i), 32'(got_cp), 32'(t_cp[i]));
    end

    // Reset landing mid-move (during CLEAR_SRC) must restore the full start position.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    req_valid = 1'b1; req_color = 1'b0; req_dir = 3'd7; king_allow = 8'h80;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("two_kings_dst", 32'(board[6][4]), 32'h19);
    check("two_kings_src", 32'(board[7][4]), 32'h19);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check_state("midrst");

    for (int i = 0; i < 150; i++) begin
      rc = ($urandom_range(0, 4) == 0) ? ~m_turn : m_turn;
      do_req(rc, 3'($urandom_range(0, 7)), 8'($urandom), got_err, got_cp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
